// File: rtl/lab8_pkg.sv
// Shared definitions for the Lab8 down timer: FSM state encodings and default count width.
package lab8_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/lab8_prescaler.sv
// Enable divider: asserts tick on every PRESCALE-th enabled cycle; clear restarts the period.
module lab8_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic E,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (E) begin
            cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
        end
    end

    // Combinational so the timer decrements on the same edge the period wraps.
    assign tick = E && (cnt == LAST);

endmodule

// File: rtl/lab8_down_timer.sv
// Loadable down-counting timer with pause, prescaler, registered expiry pulse and optional auto-reload.
module lab8_down_timer
    import lab8_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = 1,
    parameter bit RELOAD   = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             E,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             zero,
    output logic             done,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    state_t           state, state_n;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] rld;
    logic             done_n;
    logic             tick;

    lab8_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (load),
        .E     (E && (state == COUNT)),
        .tick  (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            Q     <= '0;
            rld   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            Q     <= q_n;
            done  <= done_n;
            if (load) rld <= D;
        end
    end

    // load wins over everything; only COUNT with a prescaler tick moves Q.
    always_comb begin
        state_n = state;
        q_n     = Q;
        done_n  = 1'b0;
        if (load) begin
            q_n     = D;
            state_n = (D != '0) ? COUNT : IDLE;
        end else if (state == COUNT && tick) begin
            if (Q > WIDTH'(1)) begin
                q_n = Q - WIDTH'(1);
            end else if (Q == WIDTH'(1)) begin
                done_n = 1'b1;
                if (RELOAD) begin
                    q_n = rld;
                end else begin
                    q_n     = '0;
                    state_n = EXPIRED;
                end
            end
        end
    end

    assign zero      = (Q == '0);
    assign busy      = (state == COUNT);
    assign dbg_state = state;

endmodule

// File: tb/tb_lab8_down_timer.sv
// Drives one-shot, auto-reload and prescaled timers with shared stimulus and checks them against a cycle model.
module tb_lab8_down_timer;

    localparam int N = 3;
    localparam int P_OF[N] = '{1, 1, 4};
    localparam int R_OF[N] = '{0, 1, 0};

    logic        clock;
    logic        reset;
    logic        E;
    logic        load;
    logic [15:0] D;

    logic [15:0] q_os, q_rl, q_ps;
    logic        z_os, z_rl, z_ps;
    logic        d_os, d_rl, d_ps;
    logic        b_os, b_rl, b_ps;
    logic [1:0]  s_os, s_rl, s_ps;

    int vectors;
    int miscompares;

    // Behavioural model: mode 0 idle, 1 counting, 2 expired; rem = enabled cycles until next decrement.
    int mq[N];
    int mrld[N];
    int mrem[N];
    int mmode[N];
    bit mdone[N];

    lab8_down_timer #(.WIDTH(16), .PRESCALE(1), .RELOAD(1'b0)) u_os (
        .clock(clock), .reset(reset), .E(E), .load(load), .D(D),
        .Q(q_os), .zero(z_os), .done(d_os), .busy(b_os), .dbg_state(s_os)
    );

    lab8_down_timer #(.WIDTH(16), .PRESCALE(1), .RELOAD(1'b1)) u_rl (
        .clock(clock), .reset(reset), .E(E), .load(load), .D(D),
        .Q(q_rl), .zero(z_rl), .done(d_rl), .busy(b_rl), .dbg_state(s_rl)
    );

    lab8_down_timer #(.WIDTH(16), .PRESCALE(4), .RELOAD(1'b0)) u_ps (
        .clock(clock), .reset(reset), .E(E), .load(load), .D(D),
        .Q(q_ps), .zero(z_ps), .done(d_ps), .busy(b_ps), .dbg_state(s_ps)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mq[i] = 0; mrld[i] = 0; mrem[i] = P_OF[i]; mmode[i] = 0; mdone[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++) begin
            mdone[i] = 1'b0;
            if (load) begin
                mq[i]    = int'(D);
                mrld[i]  = int'(D);
                mrem[i]  = P_OF[i];
                mmode[i] = (D != 16'd0) ? 1 : 0;
            end else if (mmode[i] == 1 && E) begin
                mrem[i] = mrem[i] - 1;
                if (mrem[i] == 0) begin
                    mrem[i] = P_OF[i];
                    if (mq[i] > 1) begin
                        mq[i] = mq[i] - 1;
                    end else begin
                        mdone[i] = 1'b1;
                        if (R_OF[i] != 0) begin
                            mq[i] = mrld[i];
                        end else begin
                            mq[i]    = 0;
                            mmode[i] = 2;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_inst(input string name, input int i, input logic [15:0] q,
                              input logic z, input logic d, input logic b, input logic [1:0] s);
        logic [31:0] mqv;
        mqv = mq[i];
        check({name, ".Q"},     32'(q), {16'd0, mqv[15:0]});
        check({name, ".zero"},  32'(z), 32'(mq[i] == 0));
        check({name, ".done"},  32'(d), 32'(mdone[i]));
        check({name, ".busy"},  32'(b), 32'(mmode[i] == 1));
        check({name, ".state"}, 32'(s), 32'(mmode[i]));
    endtask

    task automatic check_all();
        check_inst("os", 0, q_os, z_os, d_os, b_os, s_os);
        check_inst("rl", 1, q_rl, z_rl, d_rl, b_rl, s_rl);
        check_inst("ps", 2, q_ps, z_ps, d_ps, b_ps, s_ps);
    endtask

    task automatic tick_chk();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic l, input logic [15:0] d, input logic e);
        load = l;
        D    = d;
        E    = e;
        tick_chk();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        E = 1'b0; load = 1'b0; D = 16'd0;
        reset = 1'b0;
        model_reset();
        #3 reset = 1'b1;
        #1 check_all();
        repeat (2) tick_chk();
        @(negedge clock) reset = 1'b0;

        // One-shot count 3,2,1,0 with done in the 0 cycle; E then has no effect.
        drive(1'b1, 16'd3, 1'b0);
        check("os.Q_loaded", 32'(q_os), 32'd3);
        drive(1'b0, 16'd0, 1'b1);
        drive(1'b0, 16'd0, 1'b1);
        drive(1'b0, 16'd0, 1'b1);
        check("os.Q_expired", 32'(q_os), 32'd0);
        check("os.done_at_zero", 32'(d_os), 32'd1);
        check("rl.Q_reloaded", 32'(q_rl), 32'd3);
        repeat (3) drive(1'b0, 16'd0, 1'b1);
        check("os.Q_held", 32'(q_os), 32'd0);

        // Pause mid-count.
        drive(1'b1, 16'd5, 1'b0);
        repeat (2) drive(1'b0, 16'd0, 1'b1);
        check("os.Q_before_pause", 32'(q_os), 32'd3);
        repeat (4) drive(1'b0, 16'd0, 1'b0);
        check("os.Q_paused", 32'(q_os), 32'd3);
        repeat (4) drive(1'b0, 16'd0, 1'b1);

        // Load colliding with terminal decrement, then load of zero.
        drive(1'b1, 16'd2, 1'b0);
        drive(1'b0, 16'd0, 1'b1);
        check("os.Q_at_one", 32'(q_os), 32'd1);
        drive(1'b1, 16'd10, 1'b1);
        check("os.Q_collision", 32'(q_os), 32'd10);
        check("os.done_collision", 32'(d_os), 32'd0);
        drive(1'b1, 16'd0, 1'b1);
        drive(1'b0, 16'd0, 1'b1);

        // Auto-reload sequence 2,1,2,1,...
        drive(1'b1, 16'd2, 1'b1);
        repeat (6) drive(1'b0, 16'd0, 1'b1);

        // Prescaled count with a 3-cycle pause mid-period.
        drive(1'b1, 16'd2, 1'b1);
        repeat (4) drive(1'b0, 16'd0, 1'b1);
        check("ps.Q_after_4", 32'(q_ps), 32'd1);
        repeat (2) drive(1'b0, 16'd0, 1'b1);
        repeat (3) drive(1'b0, 16'd0, 1'b0);
        repeat (1) drive(1'b0, 16'd0, 1'b1);
        check("ps.done_not_yet", 32'(d_ps), 32'd0);
        drive(1'b0, 16'd0, 1'b1);
        check("ps.done_delayed", 32'(d_ps), 32'd1);
        repeat (2) drive(1'b0, 16'd0, 1'b1);

        // Asynchronous reset mid-count, observed before any clock edge.
        drive(1'b1, 16'd7, 1'b0);
        drive(1'b0, 16'd0, 1'b0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        check("os.Q_async_reset", 32'(q_os), 32'd0);
        tick_chk();
        @(negedge clock) reset = 1'b0;

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            logic        l;
            logic [15:0] d;
            logic        e;
            l = ($urandom_range(0, 11) == 0);
            d = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 9));
            e = ($urandom_range(0, 3) != 0);
            drive(l, d, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
